// File: rtl/lsu_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : lsu_mem_stage                                                     |
// | Desc   : MiniRiscV load/store unit; req/ack data-memory access with load   |
// |          extension, store lane replication and an ack timeout.            |
// |          Optional: LSU_MISALIGN_CHECK_EN rejects misaligned half/word ops. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module lsu_mem_stage #(
    parameter int ACK_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData2,
    input  logic [2:0]  funct3,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] c_to_last = TO_W'(ACK_TIMEOUT - 1);

    state_t          r_state;
    logic            r_done;
    logic            r_err;
    logic [31:0]     r_load_data;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [29:0]     r_mem_addr;
    logic [31:0]     r_mem_wdata;
    logic [3:0]      r_mem_wstrb;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic [TO_W-1:0] r_to_cnt;

    logic        w_start;
    logic        w_load_ok;
    logic        w_store_ok;
    logic        w_misalign;
    logic        w_legal;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_ext;

    assign w_start = valid & (MemRead | MemWrite);

    always_comb begin
        w_load_ok  = 1'b0;
        w_store_ok = 1'b0;
        case (funct3)
            3'd0, 3'd1, 3'd2: begin
                w_load_ok  = 1'b1;
                w_store_ok = 1'b1;
            end
            3'd4, 3'd5: w_load_ok = 1'b1;
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    // funct3[1:0] is 01 for halves and 10 for words across both loads and stores
    assign w_misalign = ((funct3[1:0] == 2'b01) & ALUResult[0]) |
                        ((funct3[1:0] == 2'b10) & (ALUResult[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_legal = (MemRead ^ MemWrite) & (MemRead ? w_load_ok : w_store_ok) & ~w_misalign;

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
        if (MemWrite) begin
            case (funct3[1:0])
                2'd0: begin
                    w_wstrb = 4'b0001 << ALUResult[1:0];
                    w_wdata = {4{ReadData2[7:0]}};
                end
                2'd1: begin
                    w_wstrb = ALUResult[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{ReadData2[15:0]}};
                end
                2'd2: begin
                    w_wstrb = 4'hF;
                    w_wdata = ReadData2;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_addr_lo)
            2'd0:    w_ld_byte = mem_rdata[7:0];
            2'd1:    w_ld_byte = mem_rdata[15:8];
            2'd2:    w_ld_byte = mem_rdata[23:16];
            default: w_ld_byte = mem_rdata[31:24];
        endcase
        w_ld_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'd0:    w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'd1:    w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
            3'd2:    w_ld_ext = mem_rdata;
            3'd4:    w_ld_ext = {24'h0, w_ld_byte};
            3'd5:    w_ld_ext = {16'h0, w_ld_half};
            default: w_ld_ext = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_load_data <= 32'h0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 30'h0;
            r_mem_wdata <= 32'h0;
            r_mem_wstrb <= 4'b0000;
            r_funct3    <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_to_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        if (w_legal) begin
                            r_state     <= ST_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= MemWrite;
                            r_mem_addr  <= ALUResult[31:2];
                            r_mem_wdata <= w_wdata;
                            r_mem_wstrb <= w_wstrb;
                            r_funct3    <= funct3;
                            r_addr_lo   <= ALUResult[1:0];
                            r_to_cnt    <= '0;
                        end else begin
                            // rejected without touching memory; load_data keeps its old value
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_err       <= 1'b0;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wstrb <= 4'b0000;
                        r_to_cnt    <= '0;
                        if (!r_mem_we) begin
                            r_load_data <= w_ld_ext;
                        end
                    end else if (r_to_cnt == c_to_last) begin
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_err       <= 1'b1;
                        r_load_data <= 32'h0;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wstrb <= 4'b0000;
                        r_to_cnt    <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // DONE releases the stall so the CPU can advance in the same cycle done pulses
    assign stall     = ((r_state == ST_IDLE) & w_start) | (r_state == ST_REQ);
    assign done      = r_done;
    assign err       = r_err;
    assign load_data = r_load_data;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_lsu_mem_stage                                                  |
// | Desc   : Directed self-checking bench for lsu_mem_stage.                   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] ReadData2;
    logic [2:0]  funct3;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    int          obs_cycles;
    int          obs_req_n;
    logic        obs_done;
    logic        obs_req_seen;
    logic        obs_unstable;
    logic        obs_stall_c1;
    logic        obs_stall_req;
    logic        obs_stall_done;
    logic        obs_req_at_done;
    logic        obs_we;
    logic [29:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_wstrb;

    lsu_mem_stage #(
        .ACK_TIMEOUT(16),
        .TO_W       (5)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ALUResult(ALUResult),
        .ReadData2(ReadData2),
        .funct3   (funct3),
        .stall    (stall),
        .done     (done),
        .load_data(load_data),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One access from an idle cycle; the bench plays memory, acking in REQ cycle ack_at (-1 = never)
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int ack_at, input logic [31:0] rdata);
        int req_n;
        @(posedge clk); #1;
        obs_cycles   = 1;
        obs_done     = 1'b0;
        obs_req_seen = 1'b0;
        obs_unstable = 1'b0;
        req_n        = 0;
        valid        = 1'b1;
        MemRead      = rd;
        MemWrite     = wr;
        funct3       = f3;
        ALUResult    = addr;
        ReadData2    = wd;
        #1 obs_stall_c1 = stall;
        for (int n = 0; n < 64 && !obs_done; n++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            obs_cycles++;
            if (done) begin
                obs_done        = 1'b1;
                obs_stall_done  = stall;
                obs_req_at_done = mem_req;
            end else if (mem_req) begin
                if (!obs_req_seen) begin
                    obs_req_seen  = 1'b1;
                    obs_we        = mem_we;
                    obs_addr      = mem_addr;
                    obs_wdata     = mem_wdata;
                    obs_wstrb     = mem_wstrb;
                    obs_stall_req = stall;
                end else if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !==
                             {obs_we, obs_addr, obs_wdata, obs_wstrb}) begin
                    obs_unstable = 1'b1;
                end
                if (req_n == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                req_n++;
            end
        end
        obs_req_n = req_n;
        valid     = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp_ld);
        run_access(1'b1, 1'b0, f3, addr, 32'h0, 0, rdata);
        chk({tag, "_done"}, 32'(obs_done), 32'h1);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_ld"}, load_data, exp_ld);
    endtask

    task automatic store_case(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] exp_strb,
                              input logic [31:0] exp_wdata, input logic [31:0] prev_ld);
        run_access(1'b0, 1'b1, f3, addr, wd, 0, 32'h0);
        chk({tag, "_done"}, 32'(obs_done), 32'h1);
        chk({tag, "_we"}, 32'(obs_we), 32'h1);
        chk({tag, "_addr"}, 32'(obs_addr), 32'(addr[31:2]));
        chk({tag, "_wstrb"}, 32'(obs_wstrb), 32'(exp_strb));
        chk({tag, "_wdata"}, obs_wdata, exp_wdata);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_ld_hold"}, load_data, prev_ld);
    endtask

    task automatic illegal_case(input string tag, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [31:0] addr);
        run_access(rd, wr, f3, addr, 32'h5555_AAAA, 0, 32'h0);
        chk({tag, "_done"}, 32'(obs_done), 32'h1);
        chk({tag, "_err"}, 32'(err), 32'h1);
        chk({tag, "_noreq"}, 32'(obs_req_seen), 32'h0);
        chk({tag, "_cycles"}, 32'(obs_cycles), 32'd2);
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        valid     = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ALUResult = 32'h0;
        ReadData2 = 32'h0;
        funct3    = 3'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_ld", load_data, 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);

        // valid alone is a no-op
        @(posedge clk); #1;
        valid = 1'b1;
        #1 chk("nop_stall", 32'(stall), 32'h0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done || mem_req) seen = 1'b1;
        end
        chk("nop_no_action", 32'(seen), 32'h0);
        valid = 1'b0;

        run_access(1'b1, 1'b0, 3'd2, 32'h0000_0104, 32'h0, 0, 32'hDEAD_BEEF);
        chk("lw_done", 32'(obs_done), 32'h1);
        chk("lw_cycles", 32'(obs_cycles), 32'd3);
        chk("lw_addr", 32'(obs_addr), 32'h41);
        chk("lw_wstrb", 32'(obs_wstrb), 32'h0);
        chk("lw_we", 32'(obs_we), 32'h0);
        chk("lw_stall_c1", 32'(obs_stall_c1), 32'h1);
        chk("lw_stall_req", 32'(obs_stall_req), 32'h1);
        chk("lw_stall_done", 32'(obs_stall_done), 32'h0);
        chk("lw_ld", load_data, 32'hDEAD_BEEF);
        chk("lw_err", 32'(err), 32'h0);

        load_case("lb",  3'd0, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80);
        load_case("lbu", 3'd4, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080);
        load_case("lb1", 3'd0, 32'h0000_0101, 32'h1234_7F56, 32'h0000_007F);
        load_case("lh",  3'd1, 32'h0000_0102, 32'h80FF_0000, 32'hFFFF_80FF);
        load_case("lhu", 3'd5, 32'h0000_0102, 32'h80FF_0000, 32'h0000_80FF);
        load_case("lh_lo", 3'd1, 32'h0000_0100, 32'h1234_9ABC, 32'hFFFF_9ABC);

`ifdef LSU_MISALIGN_CHECK_EN
        illegal_case("lh_mis", 1'b1, 1'b0, 3'd1, 32'h0000_0103);
        chk("lh_mis_ld_hold", load_data, 32'hFFFF_9ABC);
`else
        load_case("lh_odd", 3'd1, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_80FF);
`endif

        store_case("sb",  3'd0, 32'h0000_0202, 32'h1234_56AB, 4'b0100, 32'hABAB_ABAB, load_data);
        store_case("sb1", 3'd0, 32'h0000_0201, 32'h1234_56AB, 4'b0010, 32'hABAB_ABAB, load_data);
        store_case("sh",  3'd1, 32'h0000_0202, 32'h1234_56AB, 4'b1100, 32'h56AB_56AB, load_data);
        store_case("sh0", 3'd1, 32'h0000_0200, 32'h1234_56AB, 4'b0011, 32'h56AB_56AB, load_data);
        store_case("sw",  3'd2, 32'h0000_0200, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, load_data);

        run_access(1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'h0, 3, 32'h0123_4567);
        chk("lw_late_cycles", 32'(obs_cycles), 32'd6);
        chk("lw_late_stable", 32'(obs_unstable), 32'h0);
        chk("lw_late_ld", load_data, 32'h0123_4567);

        run_access(1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h0, -1, 32'h0);
        chk("to_done", 32'(obs_done), 32'h1);
        chk("to_req_cycles", 32'(obs_req_n), 32'd16);
        chk("to_cycles", 32'(obs_cycles), 32'd18);
        chk("to_err", 32'(err), 32'h1);
        chk("to_ld", load_data, 32'h0);
        chk("to_req_at_done", 32'(obs_req_at_done), 32'h0);
        chk("to_stable", 32'(obs_unstable), 32'h0);
        @(posedge clk); #1;
        chk("to_req_after", 32'(mem_req), 32'h0);

        illegal_case("ld_f3_3", 1'b1, 1'b0, 3'd3, 32'h0000_0400);
        illegal_case("rd_wr",   1'b1, 1'b1, 3'd2, 32'h0000_0400);
        illegal_case("st_f3_4", 1'b0, 1'b1, 3'd4, 32'h0000_0400);

`ifdef LSU_MISALIGN_CHECK_EN
        illegal_case("lw_mis", 1'b1, 1'b0, 3'd2, 32'h0000_0102);
`else
        run_access(1'b1, 1'b0, 3'd2, 32'h0000_0102, 32'h0, 0, 32'h1122_3344);
        chk("lw_mis_addr", 32'(obs_addr), 32'h40);
        chk("lw_mis_err", 32'(err), 32'h0);
        chk("lw_mis_ld", load_data, 32'h1122_3344);
`endif

        // asynchronous reset while a request is outstanding, then a stray ack
        @(posedge clk); #1;
        valid     = 1'b1;
        MemRead   = 1'b1;
        funct3    = 3'd2;
        ALUResult = 32'h0000_0500;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_req_pre", 32'(mem_req), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_req_drop", 32'(mem_req), 32'h0);
        chk("rst_mid_ld", load_data, 32'h0);
        valid   = 1'b0;
        MemRead = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        seen      = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (done || mem_req) seen = 1'b1;
        end
        chk("stray_ack_ignored", 32'(seen), 32'h0);

        load_case("post_rst_lw", 3'd2, 32'h0000_0600, 32'hA5A5_5A5A, 32'hA5A5_5A5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the ALU in the MiniRiscV datapath.
- Takes the ALU's load/store address result plus rs2 data and funct3, and runs a req/ack transaction to data memory.
- Returns the sign- or zero-extended load value to writeback and stalls the PC/pipeline while the access is outstanding.

Parameters:
- ACK_TIMEOUT, 16: cycles in REQ without mem_ack before the access aborts with err.
- TO_W, 5: width of the timeout counter; must hold ACK_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid  in  1  access request; held high by the CPU until done
- MemRead  in  1  load
- MemWrite  in  1  store
- ALUResult  in  32  byte address from the ALU
- ReadData2  in  32  store data (rs2)
- funct3  in  3  access size/sign
- stall  out  1  freeze PC/IF while high
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result, valid when done
- err  out  1  access error, valid when done
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  30  word address, ALUResult[31:2]
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables (all 0 on reads)
- mem_ack  in  1  memory completion, exactly one cycle
- mem_rdata  in  32  read word, valid when mem_ack=1

Behaviour:
- Reset values (async, immediate): state=IDLE, done=0, err=0, load_data=0, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, timeout counter=0.
- FSM states: IDLE, REQ, DONE.
- IDLE: when valid & (MemRead^MemWrite) and funct3 is legal, latch addr/wdata/wstrb/we/funct3 and go to REQ next cycle.
- IDLE, illegal request: funct3 illegal, or MemRead&MemWrite both set → go to DONE with err=1 and no memory request.
- REQ: mem_req=1 and all mem_* outputs held stable until mem_ack.
  - mem_ack=1 → capture the extended read value (loads) and go to DONE.
  - mem_ack is honoured in the first REQ cycle (ack in the same cycle as the request).
- REQ timeout: counter increments each REQ cycle without ack. When the count reaches ACK_TIMEOUT-1 with no ack → DONE, err=1, load_data=0. An ack in that same cycle wins (no error).
- DONE: done=1 for exactly one cycle → IDLE. load_data/err hold until the next access completes.
- stall = (IDLE & valid & (MemRead|MemWrite)) | REQ. stall=0 in DONE so the CPU advances.
- valid without MemRead/MemWrite → no action, stall=0.
- Latency: minimum 3 cycles from valid to done (IDLE→REQ with ack→DONE).
- Loads by funct3:
  - 0 lb: sign-extend byte at addr[1:0].
  - 1 lh: sign-extend half at addr[1].
  - 2 lw: full word.
  - 4 lbu: zero-extend byte.
  - 5 lhu: zero-extend half.
  - 3, 6, 7: illegal.
- Stores by funct3:
  - 0 sb: wstrb = 4'b0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - 1 sh: wstrb = addr[1]?4'b1100:4'b0011, wdata = {2{rs2[15:0]}}.
  - 2 sw: wstrb = 4'hF, wdata = rs2.
  - Others: illegal.
- Misalignment:
  - Without the optional feature, lh/lhu/sh ignore addr[0] and lw/sw ignore addr[1:0].
  - Low address bits are never forwarded to memory.
- Reset mid-transaction: mem_req drops asynchronously. A late mem_ack arriving in IDLE is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: half access with addr[0]=1, or word access with addr[1:0]≠0, goes IDLE→DONE with err=1. No mem_req, load_data unchanged.
- Undefined: low bits are masked as described above and the access proceeds normally. Such accesses never set err.

Test Plan:
- lw, ALUResult=0x0000_0104, mem_ack in 1st REQ cycle, mem_rdata=0xDEAD_BEEF → mem_addr=0x41, wstrb=0, done on cycle 3, load_data=0xDEAD_BEEF, stall high cycles 1-2.
- lb/lbu at addr 0x103, mem_rdata=0x80FF_0000 → lb gives 0xFFFF_FF80, lbu gives 0x0000_0080. lh at 0x102 gives 0xFFFF_80FF.
- sb at 0x202, rs2=0x1234_56AB → mem_we=1, wstrb=4'b0100, wdata=0xABAB_ABAB. sh at 0x202 → wstrb=4'b1100, wdata=0x56AB_56AB.
- lw with mem_ack never asserted → done with err=1 and load_data=0 exactly ACK_TIMEOUT REQ cycles after entry. mem_req drops after that.
- funct3=3 load, and MemRead&MemWrite both set → done with err=1, mem_req never asserted.
- rst pulse during REQ → mem_req=0 immediately, state IDLE. A stray ack afterwards produces no done. With LSU_MISALIGN_CHECK_EN, lw at 0x102 → err=1, no request.
